givens_internal_cell: RTL and testbench

- Systolic internal cell of the QRD-RLS array, directly downstream of the boundary cell.
- Consumes the (cos, sine) rotation pair the boundary cell produces and applies it to its stored triangular element r and the incoming sample x.
- Updates r and forwards the rotated x to the next row's cell.
- One cell per off-diagonal array position; boundary cell outputs chain along the row.

---
 rtl/qrd_pkg.sv | 31 +++
 rtl/givens_internal_cell_if.sv | 31 +++
 rtl/givens_mac.sv | 63 ++++++
 rtl/givens_internal_cell.sv | 104 ++++++++++
 tb/tb_givens_internal_cell.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD-RLS systolic array cells.
//   FRAC_BITS_DEF : default number of fractional bits (1.0 = 2^FRAC_BITS)
//   round_const   : half-LSB constant added before the fractional shift
//   sat_max/min   : two's complement limits for a given data width
//   state_t       : rotation sequencer states of the internal cell
package qrd_pkg;

  localparam int FRAC_BITS_DEF   = 6;
  localparam int ROUND_CONST_DEF = 1 << (FRAC_BITS_DEF - 1);

  function automatic int round_const(input int frac_bits);
    return 1 << (frac_bits - 1);
  endfunction

  function automatic int sat_max(input int data_length);
    return (1 << (data_length - 1)) - 1;
  endfunction

  function automatic int sat_min(input int data_length);
    return -(1 << (data_length - 1));
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    WAIT_ROT,
    MUL,
    ADD
  } state_t;

endpackage

// File: rtl/givens_internal_cell_if.sv
// Handshake/data bundle between a boundary-cell row and one internal cell.
//   master : driver side (boundary cell / row above / testbench)
//   slave  : the internal cell
//   clear, rot_valid, cos, sine, x_valid, x_in      : towards the cell
//   in_ready, x_out, x_out_valid, r_out, busy, sat_flag : from the cell
interface givens_internal_cell_if #(
  parameter int DATA_LENGTH = 8
);
  logic                          clear;
  logic                          rot_valid;
  logic signed [DATA_LENGTH-1:0] cos;
  logic signed [DATA_LENGTH-1:0] sine;
  logic                          x_valid;
  logic signed [DATA_LENGTH-1:0] x_in;
  logic                          in_ready;
  logic signed [DATA_LENGTH-1:0] x_out;
  logic                          x_out_valid;
  logic signed [DATA_LENGTH-1:0] r_out;
  logic                          busy;
  logic                          sat_flag;

  modport master (
    output clear, rot_valid, cos, sine, x_valid, x_in,
    input  in_ready, x_out, x_out_valid, r_out, busy, sat_flag
  );

  modport slave (
    input  clear, rot_valid, cos, sine, x_valid, x_in,
    output in_ready, x_out, x_out_valid, r_out, busy, sat_flag
  );
endinterface

// File: rtl/givens_mac.sv
// Two-stage Givens rotation datapath.
//   Stage 1 (mul_en edge): registers c*r, s*x, c*x, s*r.
//   Stage 2 (combinational): r_new = sat(round(c*r + s*x)),
//                            x_new = sat(round(c*x - s*r)), sat = either clamped.
// Ports: clk, rst, mul_en, c, s, r, x (operands), r_new, x_new, sat.
module givens_mac
  import qrd_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mul_en,
  input  logic signed [DATA_LENGTH-1:0] c,
  input  logic signed [DATA_LENGTH-1:0] s,
  input  logic signed [DATA_LENGTH-1:0] r,
  input  logic signed [DATA_LENGTH-1:0] x,
  output logic signed [DATA_LENGTH-1:0] r_new,
  output logic signed [DATA_LENGTH-1:0] x_new,
  output logic                          sat
);
  localparam int PW = 2 * DATA_LENGTH;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND  = SW'(round_const(FRAC_BITS));
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DATA_LENGTH));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(DATA_LENGTH));

  logic signed [PW-1:0] p_cr, p_sx, p_cx, p_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_cr <= '0;
      p_sx <= '0;
      p_cx <= '0;
      p_sr <= '0;
    end else if (mul_en) begin
      p_cr <= c * r;
      p_sx <= s * x;
      p_cx <= c * x;
      p_sr <= s * r;
    end
  end

  logic signed [SW-1:0] r_sum, x_sum, r_sh, x_sh;
  logic r_hi, r_lo, x_hi, x_lo;

  always_comb begin
    r_sum = $signed({p_cr[PW-1], p_cr}) + $signed({p_sx[PW-1], p_sx});
    x_sum = $signed({p_cx[PW-1], p_cx}) - $signed({p_sr[PW-1], p_sr});
    // Adding half an LSB then flooring with >>> gives round-half-up.
    r_sh  = (r_sum + RND) >>> FRAC_BITS;
    x_sh  = (x_sum + RND) >>> FRAC_BITS;
    r_hi  = r_sh > MAXV;
    r_lo  = r_sh < MINV;
    x_hi  = x_sh > MAXV;
    x_lo  = x_sh < MINV;
    r_new = r_hi ? MAXV[DATA_LENGTH-1:0] : r_lo ? MINV[DATA_LENGTH-1:0] : r_sh[DATA_LENGTH-1:0];
    x_new = x_hi ? MAXV[DATA_LENGTH-1:0] : x_lo ? MINV[DATA_LENGTH-1:0] : x_sh[DATA_LENGTH-1:0];
    sat   = r_hi | r_lo | x_hi | x_lo;
  end

endmodule

// File: rtl/givens_internal_cell.sv
// QRD-RLS internal (off-diagonal) systolic cell. Collects a (cos, sine) pair and
// a sample x in any order, then rotates the stored element r against x:
//   r <= c*r + s*x,  x_out <= c*x - s*r  (rounded, saturated).
// Ports: clk, rst (sync, active high) and bus (slave modport):
//   clear, rot_valid, cos, sine, x_valid, x_in -> in_ready, x_out, x_out_valid,
//   r_out, busy, sat_flag.
module givens_internal_cell
  import qrd_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
  input logic                  clk,
  input logic                  rst,
  givens_internal_cell_if.slave bus
);
  state_t state, state_nxt;

  logic signed [DATA_LENGTH-1:0] c_q, s_q, x_q, r_q, x_out_q;
  logic signed [DATA_LENGTH-1:0] r_new, x_new;
  logic                          x_out_valid_q, sat_q, mac_sat;
  logic                          in_ready, rot_take, x_take;

  assign in_ready = (state == IDLE) || (state == WAIT_X) || (state == WAIT_ROT);
  assign rot_take = bus.rot_valid && in_ready;
  assign x_take   = bus.x_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.rot_valid && bus.x_valid) state_nxt = MUL;
        else if (bus.rot_valid)           state_nxt = WAIT_X;
        else if (bus.x_valid)             state_nxt = WAIT_ROT;
      end
      WAIT_X:   if (bus.x_valid)   state_nxt = MUL;
      WAIT_ROT: if (bus.rot_valid) state_nxt = MUL;
      MUL:      state_nxt = ADD;
      ADD:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q           <= '0;
      s_q           <= '0;
      x_q           <= '0;
      r_q           <= '0;
      x_out_q       <= '0;
      x_out_valid_q <= 1'b0;
      sat_q         <= 1'b0;
    end else if (bus.clear) begin
      // x_out keeps its last value; an aborted rotation never emits.
      c_q           <= '0;
      s_q           <= '0;
      x_q           <= '0;
      r_q           <= '0;
      x_out_valid_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      if (rot_take) begin
        c_q <= bus.cos;
        s_q <= bus.sine;
      end
      if (x_take) x_q <= bus.x_in;
      x_out_valid_q <= (state == ADD);
      if (state == ADD) begin
        r_q     <= r_new;
        x_out_q <= x_new;
        sat_q   <= sat_q | mac_sat;
      end
    end
  end

  givens_mac #(
    .DATA_LENGTH(DATA_LENGTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .mul_en(state == MUL),
    .c     (c_q),
    .s     (s_q),
    .r     (r_q),
    .x     (x_q),
    .r_new (r_new),
    .x_new (x_new),
    .sat   (mac_sat)
  );

  assign bus.in_ready    = in_ready;
  assign bus.busy        = (state == MUL) || (state == ADD);
  assign bus.x_out       = x_out_q;
  assign bus.x_out_valid = x_out_valid_q;
  assign bus.r_out       = r_q;
  assign bus.sat_flag    = sat_q;

endmodule

// File: tb/tb_givens_internal_cell.sv
// Scoreboard bench for givens_internal_cell (DATA_LENGTH=8, FRAC_BITS=6).
// Drivers push expected (x_out, r_out, sat_flag, due edge) entries; a monitor
// pops one whenever x_out_valid is seen and compares.
module tb_givens_internal_cell;
  localparam int DL = 8;
  localparam int FB = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  givens_internal_cell_if #(.DATA_LENGTH(DL)) bus ();

  givens_internal_cell #(
    .DATA_LENGTH(DL),
    .FRAC_BITS  (FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int x;
    int r;
    int sat;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (prev_valid) chk("pulse_width", int'(bus.x_out_valid), 0);
    if (bus.x_out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_x_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x_out", int'(bus.x_out), e.x);
        chk("r_out", int'(bus.r_out), e.r);
        chk("sat_flag", int'(bus.sat_flag), e.sat);
        chk("latency", cyc, e.due);
      end
    end
    prev_valid = bus.x_out_valid;
  end

  task automatic idle_inputs();
    bus.clear     = 1'b0;
    bus.rot_valid = 1'b0;
    bus.x_valid   = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 12 && q.size() > 0; i++) @(negedge clk);
    chk(nm, q.size(), 0);
  endtask

  // Both operands on one edge; expected result is due two edges after accept.
  task automatic rotate(input string nm, input int c, input int s, input int x,
                        input int ex, input int er, input int es);
    exp_t e;
    @(negedge clk);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    bus.rot_valid = 1'b1;
    bus.x_valid   = 1'b1;
    bus.cos       = DL'(c);
    bus.sine      = DL'(s);
    bus.x_in      = DL'(x);
    @(posedge clk);
    #1;
    e = '{x: ex, r: er, sat: es, due: cyc + 2};
    q.push_back(e);
    @(negedge clk);
    idle_inputs();
    drain({nm, "_done"});
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst      = 1'b1;
    bus.cos  = '0;
    bus.sine = '0;
    bus.x_in = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_r_out", int'(bus.r_out), 0);
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_x_out_valid", int'(bus.x_out_valid), 0);
    chk("rst_sat_flag", int'(bus.sat_flag), 0);
    check_idle("rst");

    // Pass-through, load, 45-degree rotation, load 127
    rotate("pass",  64,  0,  32,  32,   0, 0);
    rotate("load",   0, 64,  40,   0,  40, 0);
    rotate("rot45", 45, 45,  40,   0,  56, 0);
    // x = (0*127 - 64*56 + 32) >>> 6 = -3552 >>> 6 = -56
    rotate("load127", 0, 64, 127, -56, 127, 0);

    // x first, rot four cycles later; cell waits in WAIT_ROT
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x_in    = 8'sd127;
    @(posedge clk);
    @(negedge clk);
    bus.x_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check_idle("wait_rot");
      @(negedge clk);
    end
    bus.rot_valid = 1'b1;
    bus.cos       = 8'sd64;
    bus.sine      = 8'sd64;
    @(posedge clk);
    #1;
    e = '{x: 0, r: 127, sat: 1, due: cyc + 2};
    q.push_back(e);
    @(negedge clk);
    idle_inputs();
    drain("sat_done");

    // Reset for two cycles in the middle of a rotation
    @(negedge clk);
    bus.rot_valid = 1'b1;
    bus.x_valid   = 1'b1;
    bus.cos       = 8'sd0;
    bus.sine      = 8'sd64;
    bus.x_in      = 8'sd50;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_r_out", int'(bus.r_out), 0);
    chk("mid_rst_x_out", int'(bus.x_out), 0);
    chk("mid_rst_sat_flag", int'(bus.sat_flag), 0);
    check_idle("mid_rst");
    repeat (4) @(negedge clk);

    // Give r a non-zero value, then clear while busy
    rotate("reload", 0, 64, 40, 0, 40, 0);
    @(negedge clk);
    bus.rot_valid = 1'b1;
    bus.x_valid   = 1'b1;
    bus.cos       = 8'sd64;
    bus.sine      = 8'sd0;
    bus.x_in      = 8'sd10;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("pre_clear_busy", int'(bus.busy), 1);
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clear_r_out", int'(bus.r_out), 0);
    chk("clear_sat_flag", int'(bus.sat_flag), 0);
    chk("clear_x_out_hold", int'(bus.x_out), 0);
    check_idle("clear");
    repeat (5) @(negedge clk);

    // Valids coincident with clear are dropped: no rotation starts
    bus.clear     = 1'b1;
    bus.rot_valid = 1'b1;
    bus.x_valid   = 1'b1;
    bus.x_in      = 8'sd99;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check_idle("clear_valids_1");
    @(negedge clk);
    check_idle("clear_valids_2");
    repeat (4) @(negedge clk);

    // Repeated x_valid in WAIT_ROT: last value wins
    bus.x_valid = 1'b1;
    bus.x_in    = 8'sd5;
    @(posedge clk);
    @(negedge clk);
    bus.x_in    = 8'sd20;
    @(posedge clk);
    @(negedge clk);
    bus.x_valid   = 1'b0;
    bus.rot_valid = 1'b1;
    bus.cos       = 8'sd64;
    bus.sine      = 8'sd0;
    @(posedge clk);
    #1;
    e = '{x: 20, r: 0, sat: 0, due: cyc + 2};
    q.push_back(e);
    @(negedge clk);
    idle_inputs();
    drain("last_wins_done");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
